iomem_master: RTL and testbench

- Bus initiator for the Risc-V iomem interface: takes single-word read/write commands from local logic and drives iomem_valid/addr/wdata/wstrb.
- Waits for the addressed peripheral's ready, then returns read data on a response handshake.
- Lets non-CPU blocks (DSP sequencers, test harnesses) reach iomem peripherals, and serves as the bench driver for responder blocks.

---
 rtl/iomem_pkg.sv | 15 +
 rtl/iomem_timeout.sv | 32 +++
 rtl/iomem_master.sv | 123 ++++++++++++
 tb/tb_iomem_master.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_pkg.sv
// iomem_pkg: shared types and widths for the iomem bus initiator.
package iomem_pkg;

   localparam int IOMEM_AW              = 32;
   localparam int IOMEM_DW              = 32;
   localparam int IOMEM_SW              = 4;
   localparam int IOMEM_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

endpackage

// File: rtl/iomem_timeout.sv
// iomem_timeout: clearable, enable-gated saturating cycle counter.
// expired is high while the count equals LIMIT. It is used only when
// IOMEM_MASTER_TIMEOUT_EN is defined.
module iomem_timeout #(
   parameter int TW    = 8,
   parameter int LIMIT = 255
) (
   input  logic ck,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [TW-1:0] LIMIT_V = TW'(LIMIT);

   logic [TW-1:0] count;

   // Clear wins over count; the counter saturates at all-ones.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + TW'(1);
      end
   end

   assign expired = (count == LIMIT_V);

endmodule

// File: rtl/iomem_master.sv
// iomem_master: single-outstanding iomem bus initiator.
// A command accepted in IDLE is issued on the bus in REQ. The response is
// then offered in RSP until it is consumed.
// Optional IOMEM_MASTER_TIMEOUT_EN: abort REQ after TIMEOUT cycles without
// iomem_ready, and flag the abort on rsp_err.
module iomem_master
   import iomem_pkg::*;
#(
   parameter int TIMEOUT = IOMEM_TIMEOUT_DEFAULT,
   parameter int TW      = 8
) (
   input  logic                ck,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_we,
   input  logic [IOMEM_AW-1:0] cmd_addr,
   input  logic [IOMEM_DW-1:0] cmd_wdata,
   input  logic [IOMEM_SW-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IOMEM_DW-1:0] rsp_rdata,
   output logic                rsp_err,
   output logic                iomem_valid,
   input  logic                iomem_ready,
   output logic [IOMEM_AW-1:0] iomem_addr,
   output logic [IOMEM_DW-1:0] iomem_wdata,
   output logic [IOMEM_SW-1:0] iomem_wstrb,
   input  logic [IOMEM_DW-1:0] iomem_rdata
);

   state_t state, state_next;
   logic   accept;
   logic   expired;
   logic   is_read;

   assign accept  = cmd_valid && cmd_ready;
   // A write with no strobes is issued on the bus as a read, so the response
   // returns bus data for it.
   assign is_read = (iomem_wstrb == '0);

`ifdef IOMEM_MASTER_TIMEOUT_EN
   iomem_timeout #(
      .TW   (TW),
      .LIMIT(TIMEOUT)
   ) u_timeout (
      .ck     (ck),
      .rst    (rst),
      .clr    (accept),
      .en     (iomem_valid && !iomem_ready),
      .expired(expired)
   );
`else
   assign expired = 1'b0;
`endif

   // State register. Reset leaves REQ at once, so iomem_valid drops asynchronously.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         // NOTE: use non-blocking (<=) for every flop. Blocking assignments in a
         // clocked block create read-order races between processes.
         state <= state_next;
      end
   end

   // Next state and handshake outputs.
   always_comb begin
      // NOTE: assign defaults first. Any path that leaves a signal unassigned
      // in always_comb infers a latch.
      state_next  = state;
      cmd_ready   = 1'b0;
      iomem_valid = 1'b0;
      rsp_valid   = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = !rst;
            if (accept) state_next = REQ;
         end
         REQ: begin
            iomem_valid = 1'b1;
            // Ready on the expiry edge wins over the timeout.
            if (iomem_ready || expired) state_next = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus fields are latched on accept and held. Response fields are latched on
   // completion or on timeout.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         // NOTE: these registers drive ports, so each one gets a reset value.
         // Storage arrays would normally be left unreset.
         iomem_addr  <= '0;
         iomem_wdata <= '0;
         iomem_wstrb <= '0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
      end else begin
         if (accept) begin
            iomem_addr  <= cmd_addr;
            iomem_wdata <= cmd_wdata;
            iomem_wstrb <= cmd_we ? cmd_wstrb : '0;
         end
         if (state == REQ) begin
            if (iomem_ready) begin
               rsp_rdata <= is_read ? iomem_rdata : '0;
               rsp_err   <= 1'b0;
            end else if (expired) begin
               rsp_rdata <= '0;
               rsp_err   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_iomem_master.sv
// tb_iomem_master: directed bench for iomem_master.
// Inputs are driven and outputs sampled on the negedge. The timeout scenario
// runs only when IOMEM_MASTER_TIMEOUT_EN is defined.
module tb_iomem_master;

   logic        ck = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        iomem_valid;
   logic        iomem_ready;
   logic [31:0] iomem_addr;
   logic [31:0] iomem_wdata;
   logic [3:0]  iomem_wstrb;
   logic [31:0] iomem_rdata;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] RD_KEY = 32'h5A5A_0000;

   iomem_master #(.TIMEOUT(4), .TW(8)) dut (
      .ck         (ck),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_we     (cmd_we),
      .cmd_addr   (cmd_addr),
      .cmd_wdata  (cmd_wdata),
      .cmd_wstrb  (cmd_wstrb),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .iomem_valid(iomem_valid),
      .iomem_ready(iomem_ready),
      .iomem_addr (iomem_addr),
      .iomem_wdata(iomem_wdata),
      .iomem_wstrb(iomem_wstrb),
      .iomem_rdata(iomem_rdata)
   );

   always #5 ck = ~ck;

   task automatic test_reset();
      #1;
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
      checks++; if (iomem_valid !== 1'b0) begin failures++; $display("FAIL rst_iomem_valid got=%b exp=0", iomem_valid); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (iomem_addr !== 32'h0) begin failures++; $display("FAIL rst_iomem_addr got=%h exp=0", iomem_addr); end
      checks++; if (iomem_wdata !== 32'h0) begin failures++; $display("FAIL rst_iomem_wdata got=%h exp=0", iomem_wdata); end
      checks++; if (iomem_wstrb !== 4'h0) begin failures++; $display("FAIL rst_iomem_wstrb got=%h exp=0", iomem_wstrb); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp_rdata got=%h exp=0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rst_rsp_err got=%b exp=0", rsp_err); end
      @(negedge ck);
      @(negedge ck);
      rst = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_release_cmd_ready got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_read_zero_wait();
      @(negedge ck);
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rd0_cmd_ready got=%b exp=1", cmd_ready); end
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h6000_0010;
      cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
      @(negedge ck);
      cmd_valid = 1'b0;
      checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL rd0_iomem_valid got=%b exp=1", iomem_valid); end
      checks++; if (iomem_addr !== 32'h6000_0010) begin failures++; $display("FAIL rd0_iomem_addr got=%h exp=60000010", iomem_addr); end
      checks++; if (iomem_wstrb !== 4'h0) begin failures++; $display("FAIL rd0_iomem_wstrb got=%h exp=0", iomem_wstrb); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd0_rsp_early got=%b exp=0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL rd0_cmd_ready_req got=%b exp=0", cmd_ready); end
      iomem_ready = 1'b1; iomem_rdata = 32'hDEAD_BEEF;
      @(negedge ck);
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      checks++; if (iomem_valid !== 1'b0) begin failures++; $display("FAIL rd0_valid_drop got=%b exp=0", iomem_valid); end
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL rd0_rsp_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd0_rsp_rdata got=%h exp=deadbeef", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL rd0_rsp_err got=%b exp=0", rsp_err); end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rd0_rsp_drop got=%b exp=0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rd0_idle_cmd_ready got=%b exp=1", cmd_ready); end
   endtask

   task automatic test_write_wait3();
      @(negedge ck);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h6000_0004;
      cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'b0011;
      @(negedge ck);
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL wr3_valid[%0d] got=%b exp=1", i, iomem_valid); end
         checks++; if (iomem_addr !== 32'h6000_0004) begin failures++; $display("FAIL wr3_addr[%0d] got=%h exp=60000004", i, iomem_addr); end
         checks++; if (iomem_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr3_wdata[%0d] got=%h exp=12345678", i, iomem_wdata); end
         checks++; if (iomem_wstrb !== 4'b0011) begin failures++; $display("FAIL wr3_wstrb[%0d] got=%h exp=3", i, iomem_wstrb); end
         if (i == 3) begin
            iomem_ready = 1'b1; iomem_rdata = 32'hFFFF_FFFF;
         end
         @(negedge ck);
      end
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL wr3_rsp_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL wr3_rsp_rdata got=%h exp=0", rsp_rdata); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL wr3_rsp_err got=%b exp=0", rsp_err); end
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h6000_0008; cmd_wstrb = 4'hF;
      @(negedge ck);
      rsp_ready = 1'b0;
      checks++; if (iomem_valid !== 1'b0) begin failures++; $display("FAIL wr3_idle_gap got=%b exp=0", iomem_valid); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL wr3_gap_cmd_ready got=%b exp=1", cmd_ready); end
      @(negedge ck);
      cmd_valid = 1'b0;
      checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL wr3_next_valid got=%b exp=1", iomem_valid); end
      checks++; if (iomem_addr !== 32'h6000_0008) begin failures++; $display("FAIL wr3_next_addr got=%h exp=60000008", iomem_addr); end
      checks++; if (iomem_wstrb !== 4'h0) begin failures++; $display("FAIL wr3_next_wstrb got=%h exp=0", iomem_wstrb); end
      iomem_ready = 1'b1; iomem_rdata = 32'h0000_00A5;
      @(negedge ck);
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      checks++; if (rsp_rdata !== 32'h0000_00A5) begin failures++; $display("FAIL wr3_next_rdata got=%h exp=000000a5", rsp_rdata); end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
   endtask

   task automatic test_back_pressure();
      @(negedge ck);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h6000_0020; cmd_wstrb = 4'h0;
      @(negedge ck);
      cmd_valid = 1'b0;
      iomem_ready = 1'b1; iomem_rdata = 32'h1111_2222;
      @(negedge ck);
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      cmd_valid = 1'b1; cmd_addr = 32'h6000_0024;
      for (int i = 0; i < 5; i++) begin
         checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL bp_cmd_ready[%0d] got=%b exp=0", i, cmd_ready); end
         checks++; if (iomem_valid !== 1'b0) begin failures++; $display("FAIL bp_iomem_valid[%0d] got=%b exp=0", i, iomem_valid); end
         checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL bp_rsp_valid[%0d] got=%b exp=1", i, rsp_valid); end
         checks++; if (rsp_rdata !== 32'h1111_2222) begin failures++; $display("FAIL bp_rsp_rdata[%0d] got=%h exp=11112222", i, rsp_rdata); end
         @(negedge ck);
      end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_rsp_drop got=%b exp=0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL bp_cmd_ready_idle got=%b exp=1", cmd_ready); end
      @(negedge ck);
      cmd_valid = 1'b0;
      checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL bp_next_valid got=%b exp=1", iomem_valid); end
      checks++; if (iomem_addr !== 32'h6000_0024) begin failures++; $display("FAIL bp_next_addr got=%h exp=60000024", iomem_addr); end
      iomem_ready = 1'b1; iomem_rdata = 32'h3333_4444;
      @(negedge ck);
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      checks++; if (rsp_rdata !== 32'h3333_4444) begin failures++; $display("FAIL bp_next_rdata got=%h exp=33334444", rsp_rdata); end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_req();
      @(negedge ck);
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h6000_0030;
      cmd_wdata = 32'hCAFE_0001; cmd_wstrb = 4'hF;
      @(negedge ck);
      cmd_valid = 1'b0;
      checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL arst_pre_valid got=%b exp=1", iomem_valid); end
      #2 rst = 1'b1;
      #1;
      checks++; if (iomem_valid !== 1'b0) begin failures++; $display("FAIL arst_iomem_valid got=%b exp=0", iomem_valid); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL arst_rsp_valid got=%b exp=0", rsp_valid); end
      checks++; if (cmd_ready !== 1'b0) begin failures++; $display("FAIL arst_cmd_ready got=%b exp=0", cmd_ready); end
      checks++; if (iomem_addr !== 32'h0) begin failures++; $display("FAIL arst_iomem_addr got=%h exp=0", iomem_addr); end
      @(negedge ck);
      rst = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL arst_release_cmd_ready got=%b exp=1", cmd_ready); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL arst_no_rsp got=%b exp=0", rsp_valid); end
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h6000_0034; cmd_wstrb = 4'h0;
      @(negedge ck);
      cmd_valid = 1'b0;
      checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL arst_next_valid got=%b exp=1", iomem_valid); end
      checks++; if (iomem_addr !== 32'h6000_0034) begin failures++; $display("FAIL arst_next_addr got=%h exp=60000034", iomem_addr); end
      iomem_ready = 1'b1; iomem_rdata = 32'h7777_8888;
      @(negedge ck);
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL arst_next_rsp got=%b exp=1", rsp_valid); end
      checks++; if (rsp_rdata !== 32'h7777_8888) begin failures++; $display("FAIL arst_next_rdata got=%h exp=77778888", rsp_rdata); end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
   endtask

`ifdef IOMEM_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      // The responder never answers: the bus is held for 5 REQ cycles, then the request is aborted.
      @(negedge ck);
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h6000_0040; cmd_wstrb = 4'h0;
      @(negedge ck);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL to_valid[%0d] got=%b exp=1", i, iomem_valid); end
         @(negedge ck);
      end
      checks++; if (iomem_valid !== 1'b0) begin failures++; $display("FAIL to_valid_drop got=%b exp=0", iomem_valid); end
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp_valid got=%b exp=1", rsp_valid); end
      checks++; if (rsp_err !== 1'b1) begin failures++; $display("FAIL to_rsp_err got=%b exp=1", rsp_err); end
      checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_rsp_rdata got=%h exp=0", rsp_rdata); end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
      // Ready on the expiry edge: normal completion.
      cmd_valid = 1'b1; cmd_addr = 32'h6000_0044;
      @(negedge ck);
      cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if (iomem_valid !== 1'b1) begin failures++; $display("FAIL to_edge_valid[%0d] got=%b exp=1", i, iomem_valid); end
         if (i == 4) begin
            iomem_ready = 1'b1; iomem_rdata = 32'h0BAD_F00D;
         end
         @(negedge ck);
      end
      iomem_ready = 1'b0; iomem_rdata = 32'h0;
      checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL to_edge_rsp got=%b exp=1", rsp_valid); end
      checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL to_edge_err got=%b exp=0", rsp_err); end
      checks++; if (rsp_rdata !== 32'h0BAD_F00D) begin failures++; $display("FAIL to_edge_rdata got=%h exp=0badf00d", rsp_rdata); end
      rsp_ready = 1'b1;
      @(negedge ck);
      rsp_ready = 1'b0;
   endtask
`endif

   task automatic test_back_to_back();
      logic        t_we    [8];
      logic [31:0] t_addr  [8];
      logic [31:0] t_wdata [8];
      logic [3:0]  t_wstrb [8];
      logic [3:0]  e_wstrb [8];
      logic [31:0] e_rdata [8];
      int          acc_cyc [8];
      int          idx;
      int          rsp_idx;
      int          cyc;
      bit          pending;
      // Reference model: reads and zero-strobe writes return addr ^ RD_KEY.
      // Other writes return 0.
      for (int i = 0; i < 8; i++) begin
         t_we[i]    = (i % 2) == 1;
         t_addr[i]  = 32'h6000_0100 + 32'(i * 4);
         t_wdata[i] = 32'hA000_0000 | 32'(i);
         t_wstrb[i] = (i == 5) ? 4'h0 : 4'(4'h1 << (i % 4));
         e_wstrb[i] = t_we[i] ? t_wstrb[i] : 4'h0;
         e_rdata[i] = (e_wstrb[i] == 4'h0) ? (t_addr[i] ^ RD_KEY) : 32'h0;
         acc_cyc[i] = 0;
      end
      idx = 0; rsp_idx = 0; cyc = 0; pending = 1'b0;
      @(negedge ck);
      rsp_ready = 1'b1;
      cmd_valid = 1'b1; cmd_we = t_we[0]; cmd_addr = t_addr[0];
      cmd_wdata = t_wdata[0]; cmd_wstrb = t_wstrb[0];
      while (rsp_idx < 8 && cyc < 200) begin
         if (pending) begin
            pending = 1'b0;
            idx++;
            if (idx < 8) begin
               cmd_we = t_we[idx]; cmd_addr = t_addr[idx];
               cmd_wdata = t_wdata[idx]; cmd_wstrb = t_wstrb[idx];
            end else begin
               cmd_valid = 1'b0;
            end
         end
         if (cmd_valid && cmd_ready) begin
            pending = 1'b1;
            acc_cyc[idx] = cyc;
            if (idx > 0) begin
               checks++; if (acc_cyc[idx] - acc_cyc[idx-1] < 3) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp>=3", idx, acc_cyc[idx] - acc_cyc[idx-1]); end
            end
         end
         if (iomem_valid) begin
            checks++; if (iomem_addr !== t_addr[rsp_idx]) begin failures++; $display("FAIL b2b_addr[%0d] got=%h exp=%h", rsp_idx, iomem_addr, t_addr[rsp_idx]); end
            checks++; if (iomem_wstrb !== e_wstrb[rsp_idx]) begin failures++; $display("FAIL b2b_wstrb[%0d] got=%h exp=%h", rsp_idx, iomem_wstrb, e_wstrb[rsp_idx]); end
            if (t_we[rsp_idx]) begin
               checks++; if (iomem_wdata !== t_wdata[rsp_idx]) begin failures++; $display("FAIL b2b_wdata[%0d] got=%h exp=%h", rsp_idx, iomem_wdata, t_wdata[rsp_idx]); end
            end
            iomem_ready = 1'b1; iomem_rdata = iomem_addr ^ RD_KEY;
         end else begin
            iomem_ready = 1'b0; iomem_rdata = 32'h0;
         end
         if (rsp_valid) begin
            checks++; if (rsp_rdata !== e_rdata[rsp_idx]) begin failures++; $display("FAIL b2b_rdata[%0d] got=%h exp=%h", rsp_idx, rsp_rdata, e_rdata[rsp_idx]); end
            checks++; if (rsp_err !== 1'b0) begin failures++; $display("FAIL b2b_err[%0d] got=%b exp=0", rsp_idx, rsp_err); end
            checks++; if (cyc - acc_cyc[rsp_idx] != 2) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=2", rsp_idx, cyc - acc_cyc[rsp_idx]); end
            rsp_idx++;
         end
         @(negedge ck);
         cyc++;
      end
      checks++; if (rsp_idx != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", rsp_idx); end
      cmd_valid = 1'b0; rsp_ready = 1'b0; iomem_ready = 1'b0; iomem_rdata = 32'h0;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
      rsp_ready = 1'b0; iomem_ready = 1'b0; iomem_rdata = 32'h0;
      test_reset();
      test_read_zero_wait();
      test_write_wait3();
      test_back_pressure();
      test_reset_mid_req();
`ifdef IOMEM_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "simulation watchdog expired");
   end

endmodule
